// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types and constants for the instruction-memory boot loader.
// Contents: boot FSM state type, header length and word width in bytes.
// Used by imem_boot_ctrl, imem_word_assembler and the bench model.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CKSUM = 3'd4,
        RUN   = 3'd5,
        ERR   = 3'd6
    } boot_state_e;

    localparam int BOOT_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs accepted loader bytes into a big-endian 32-bit word.
// Ports: clk/rst, clr_i (zero index/word/xor), shift_i + byte_i (one byte in),
//        word_o (assembled word), last_o (next shift completes a word), xor_o (IMEM_BOOT_CKSUM_EN only).
// Latency: word_o is valid the cycle after the 4th shift; no backpressure of its own.
module imem_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
`ifdef IMEM_BOOT_CKSUM_EN
    ,
    output logic [7:0]  xor_o
`endif
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [31:0] word_q, word_d;
    logic [1:0]  bidx_q, bidx_d;

    // First byte of a word ends up in [31:24] after four shifts.
    always_comb begin
        word_d = word_q;
        bidx_d = bidx_q;
        if (clr_i) begin
            word_d = '0;
            bidx_d = '0;
        end else if (shift_i) begin
            word_d = {word_q[23:0], byte_i};
            bidx_d = bidx_q + 2'd1;  // wraps to 0 after the 4th byte
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            bidx_q <= '0;
        end else begin
            word_q <= word_d;
            bidx_q <= bidx_d;
        end
    end

    assign word_o = word_q;
    assign last_o = (bidx_q == LAST_IDX);

`ifdef IMEM_BOOT_CKSUM_EN
    logic [7:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (clr_i)
            xor_d = '0;
        else if (shift_i)
            xor_d = xor_q ^ byte_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xor_q <= '0;
        else
            xor_q <= xor_d;
    end

    assign xor_o = xor_q;
`endif

endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot loader + address-port arbiter for the instruction memory.
// Ports: clk/reset, fetch_a (CPU fetch), in_valid/in_data/in_ready (loader bytes), restart,
//        mem_a/mem_we/mem_wd (memory port), cpu_hold/boot_done/boot_err (status).
// Latency: word write one cycle after its 4th byte (in_ready low for that cycle only).
// Optional: define IMEM_BOOT_CKSUM_EN to require a trailing XOR checksum byte before RUN.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int          MEM_SIZE  = 1024,
    parameter logic [31:0] BOOT_BASE = 32'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_a,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [15:0] CNT_MAX = 16'(MEM_SIZE - 1);

    // State entered once the last word (or an empty header) has been handled.
`ifdef IMEM_BOOT_CKSUM_EN
    localparam boot_state_e LOAD_END = CKSUM;
`else
    localparam boot_state_e LOAD_END = RUN;
`endif

    boot_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ptr_q, ptr_d;
    logic        accept;
    logic        asm_shift;
    logic        asm_clr;
    logic        asm_last;
    logic [31:0] asm_word;
    logic [15:0] hdr_cnt;
`ifdef IMEM_BOOT_CKSUM_EN
    logic [7:0]  asm_xor;
`endif

    assign in_ready = (state_q == HDR0) || (state_q == HDR1) ||
                      (state_q == DATA) || (state_q == CKSUM);
    // A byte offered alongside restart is dropped.
    assign accept    = in_valid && in_ready && !restart;
    assign asm_shift = accept && (state_q == DATA);
    assign asm_clr   = restart || (accept && (state_q == HDR1));
    assign hdr_cnt   = {cnt_q[15:8], in_data};

    imem_word_assembler u_asm (
        .clk     (clk),
        .rst     (reset),
        .clr_i   (asm_clr),
        .shift_i (asm_shift),
        .byte_i  (in_data),
        .word_o  (asm_word),
        .last_o  (asm_last)
`ifdef IMEM_BOOT_CKSUM_EN
        ,
        .xor_o   (asm_xor)
`endif
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            HDR0: if (accept) begin
                cnt_d   = {in_data, 8'h00};
                state_d = HDR1;
            end
            HDR1: if (accept) begin
                cnt_d = hdr_cnt;
                if (hdr_cnt == 16'd0) begin
                    state_d = LOAD_END;
                end else if (hdr_cnt > CNT_MAX) begin
                    state_d = ERR;
                end else begin
                    state_d = DATA;
                    ptr_d   = BOOT_BASE;
                end
            end
            DATA: if (accept && asm_last) state_d = WRITE;
            WRITE: begin
                ptr_d   = ptr_q + 32'd4;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? LOAD_END : DATA;
            end
`ifdef IMEM_BOOT_CKSUM_EN
            CKSUM: if (accept) state_d = (in_data == asm_xor) ? RUN : ERR;
`endif
            default: state_d = state_q;  // RUN and ERR are sticky
        endcase
        if (restart) begin
            state_d = HDR0;
            cnt_d   = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HDR0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // The CPU only owns the address port once the load has completed.
    assign mem_a     = (state_q == RUN) ? fetch_a : ptr_q;
    assign mem_we    = (state_q == WRITE);
    assign mem_wd    = mem_we ? asm_word : 32'd0;
    assign cpu_hold  = (state_q != RUN);
    assign boot_done = (state_q == RUN);
    assign boot_err  = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;
    import imem_boot_pkg::*;

    localparam int          MEM_SIZE  = 1024;
    localparam logic [31:0] BOOT_BASE = 32'h4;

    logic        clk, reset, in_valid, in_ready, restart, mem_we, cpu_hold, boot_done, boot_err;
    logic [31:0] fetch_a, mem_a, mem_wd;
    logic [7:0]  in_data;

    imem_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .BOOT_BASE(BOOT_BASE)) dut (
        .clk(clk), .reset(reset), .fetch_a(fetch_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_err(boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic fetch_rand = 1'b1;
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [7:0]  stream[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: counts bytes and words -------------
    int          nacc;       // bytes accepted since load start (header included)
    int          nwr;        // words already written
    logic [15:0] m_cnt;      // header word count
    logic [31:0] m_wbuf, m_pend_word;
    logic        m_wr_pend;  // a completed word is due on the port this cycle
    logic [7:0]  m_xor;
    logic        m_cks_seen, m_cks_ok;
    logic        m_legal, m_data_done, m_done, m_err, m_rdy;

    task automatic model_clear();
        nacc = 0; nwr = 0; m_cnt = '0; m_wbuf = '0; m_pend_word = '0;
        m_wr_pend = 1'b0; m_xor = '0; m_cks_seen = 1'b0; m_cks_ok = 1'b0;
    endtask

    task automatic model_flags();
        logic hdr_in, empty, hdr_err;
        hdr_in      = (nacc >= BOOT_HDR_BYTES);
        empty       = hdr_in && (m_cnt == 16'd0);
        m_legal     = hdr_in && (m_cnt != 16'd0) && (int'(m_cnt) <= MEM_SIZE - 1);
        hdr_err     = hdr_in && (int'(m_cnt) > MEM_SIZE - 1);
        m_data_done = empty || (m_legal && (nwr == int'(m_cnt)));
`ifdef IMEM_BOOT_CKSUM_EN
        m_done = m_data_done && m_cks_seen && m_cks_ok;
        m_err  = hdr_err || (m_cks_seen && !m_cks_ok);
`else
        m_done = m_data_done;
        m_err  = hdr_err;
`endif
        m_rdy = !m_done && !m_err && !m_wr_pend;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset || restart) begin
                model_clear();
            end else begin
                logic acc;
                model_flags();
                acc = in_valid && m_rdy;
                if (m_wr_pend) begin
                    m_wr_pend = 1'b0;
                    nwr++;
                end
                if (acc) begin
                    if (nacc < BOOT_HDR_BYTES) begin
                        m_cnt = {m_cnt[7:0], in_data};
                    end else if (m_data_done) begin
                        m_cks_seen = 1'b1;
                        m_cks_ok   = (in_data == m_xor);
                    end else begin
                        m_wbuf = {m_wbuf[23:0], in_data};
                        m_xor  = m_xor ^ in_data;
                        if ((nacc - BOOT_HDR_BYTES) % BYTES_PER_WORD == BYTES_PER_WORD - 1) begin
                            m_wr_pend   = 1'b1;
                            m_pend_word = m_wbuf;
                        end
                    end
                    nacc++;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model -------------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            model_flags();
            check("in_ready", in_ready, m_rdy);
            check("mem_we", mem_we, m_wr_pend);
            check("mem_wd", mem_wd, m_wr_pend ? m_pend_word : 32'd0);
            check("mem_a", mem_a, m_done ? fetch_a : (m_legal ? BOOT_BASE + 32'(4 * nwr) : 32'd0));
            check("cpu_hold", cpu_hold, !m_done);
            check("boot_done", boot_done, m_done);
            check("boot_err", boot_err, m_err);
            if (mem_we) begin
                log_a.push_back(mem_a);
                log_d.push_back(mem_wd);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (fetch_rand) fetch_a = $urandom;
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            t++;
            if (t > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    // maxgap < 0 means a fixed gap of -maxgap idle cycles before every byte
    task automatic send_stream(input int maxgap);
        foreach (stream[i])
            send_byte(stream[i], (maxgap < 0) ? -maxgap : int'($urandom_range(maxgap, 0)));
    endtask

    task automatic add_cksum();
`ifdef IMEM_BOOT_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = BOOT_HDR_BYTES; i < stream.size(); i++) x ^= stream[i];
        stream.push_back(x);
`endif
    endtask

    task automatic pulse_restart();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        log_a.delete();
        log_d.delete();
    endtask

    task automatic random_load(input int nwords);
        stream = {8'(nwords >> 8), 8'(nwords)};
        for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
        add_cksum();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------------------------------
    initial begin
        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = '0; fetch_a = '0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_boot_done", boot_done, 0);
        check("rst_boot_err", boot_err, 0);
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // two-word load, literal expectations
        stream = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h13};
        add_cksum();
        send_stream(0);
        repeat (3) tick();
        check("t1_nwrites", log_a.size(), 2);
        if (log_a.size() == 2) begin
            check("t1_a0", log_a[0], 32'h4);
            check("t1_d0", log_d[0], 32'hDEADBEEF);
            check("t1_a1", log_a[1], 32'h8);
            check("t1_d1", log_d[1], 32'h00000113);
        end
        check("t1_boot_done", boot_done, 1);
        check("t1_cpu_hold", cpu_hold, 0);
        fetch_rand = 1'b0;
        fetch_a = 32'h10;
        #1;
        check("t1_fetch_pass", mem_a, 32'h10);
        fetch_rand = 1'b1;

        // empty program
        pulse_restart();
        stream = {8'h00, 8'h00};
        add_cksum();
        send_stream(0);
        repeat (2) tick();
        check("t2_nwrites", log_a.size(), 0);
        check("t2_boot_done", boot_done, 1);

        // illegal count, then restart and a good load
        pulse_restart();
        stream = {8'h04, 8'h00};
        send_stream(0);
        tick();
        check("t3_boot_err", boot_err, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_cpu_hold", cpu_hold, 1);
        pulse_restart();
        check("t3_err_clear", boot_err, 0);
        stream = {8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        add_cksum();
        send_stream(0);
        repeat (3) tick();
        check("t3_nwrites", log_a.size(), 1);
        if (log_a.size() == 1) check("t3_d0", log_d[0], 32'hA1B2C3D4);
        check("t3_boot_done", boot_done, 1);

        // largest legal count is accepted (not an error)
        pulse_restart();
        stream = {8'h03, 8'hFF, 8'h01, 8'h02};
        send_stream(0);
        check("t3b_no_err", boot_err, 0);
        check("t3b_ready", in_ready, 1);

        // valid toggling every other cycle
        pulse_restart();
        stream = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC};
        add_cksum();
        send_stream(-1);
        repeat (3) tick();
        check("t4_nwrites", log_a.size(), 3);
        if (log_a.size() == 3) begin
            check("t4_d0", log_d[0], 32'h11223344);
            check("t4_d2", log_d[2], 32'h99AABBCC);
            check("t4_a2", log_a[2], 32'h0000000C);
        end

        // async reset in the middle of word 3
        pulse_restart();
        stream = {8'h00, 8'h04};
        for (int i = 0; i < 10; i++) stream.push_back(8'(i + 1));
        send_stream(0);
        #1;
        reset = 1'b1;
        #1;
        check("t5_in_ready", in_ready, 1);
        check("t5_mem_a", mem_a, 0);
        check("t5_mem_we", mem_we, 0);
        check("t5_cpu_hold", cpu_hold, 1);
        check("t5_boot_done", boot_done, 0);
        tick();
        reset = 1'b0;
        log_a.delete();
        log_d.delete();
        random_load(5);
        send_stream(2);
        repeat (3) tick();
        check("t5_nwrites", log_a.size(), 5);
        check("t5_boot_done", boot_done, 1);

`ifdef IMEM_BOOT_CKSUM_EN
        pulse_restart();
        stream = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_stream(0);
        repeat (2) tick();
        check("t6_good_done", boot_done, 1);
        pulse_restart();
        stream = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_stream(0);
        repeat (2) tick();
        check("t6_bad_err", boot_err, 1);
`endif

        // randomized loads, some aborted by restart, some with bad headers
        for (int it = 0; it < 12; it++) begin
            pulse_restart();
            if (it % 4 == 3) begin
                stream = {8'h00, 8'h00};
                stream[0] = 8'($urandom_range(255, 4));
                stream[1] = 8'($urandom);
                send_stream(1);
                repeat (2) tick();
            end else begin
                random_load($urandom_range(6, 1));
                if (it % 4 == 2) begin
                    int cut;
                    cut = $urandom_range(stream.size() - 1, 1);
                    for (int i = 0; i < cut; i++) send_byte(stream[i], $urandom_range(2, 0));
                end else begin
                    send_stream(2);
                    repeat (3) tick();
                end
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot sequencer and port arbiter for the instruction memory. After reset it owns the memory's single address/write port and receives a byte stream: a 2-byte word-count header, then program words. It assembles each 4-byte group into a word and writes it starting at BOOT_BASE, while holding the CPU in reset-hold. When the load finishes, it hands the address port back to the CPU fetch path.

Parameters:
MEM_SIZE, 1024, memory depth in 32-bit words
BOOT_BASE, 32'h4, byte address of first loaded word (word 0 holds boot ROM stack-pointer init)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
fetch_a  in  32  CPU fetch byte address
in_valid  in  1  loader byte valid
in_data  in  8  loader byte
in_ready  out  1  controller accepts byte this cycle
restart  in  1  re-enter boot load (synchronous pulse)
mem_a  out  32  byte address to instruction memory
mem_we  out  1  word write strobe to instruction memory
mem_wd  out  32  write word, byte at mem_a in [31:24] (big-endian within word, matches memory read order)
cpu_hold  out  1  CPU held (PC frozen at 0) while high
boot_done  out  1  load complete, CPU running
boot_err  out  1  header count illegal (or checksum fail, see option)

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values: state=HDR0; in_ready=1; mem_we=0; mem_wd=0; mem_a=0; cpu_hold=1; boot_done=0; boot_err=0; internal count, byte index and word pointer all 0.
- Handshake: a byte transfers on a rising edge with in_valid&&in_ready. in_ready is combinational from state (high in HDR0, HDR1, DATA; low otherwise).
- HDR0: accepted byte goes to cnt[15:8] -> HDR1.
- HDR1: accepted byte goes to cnt[7:0], then:
  - cnt==0 -> RUN (empty program is legal).
  - cnt > MEM_SIZE-1 -> ERR.
  - otherwise -> DATA, with ptr=BOOT_BASE and bidx=0.
- DATA: accepted byte shifts into an assembly register, first byte ending in [31:24]. On the 4th byte (bidx==3) -> WRITE.
- WRITE: lasts exactly one cycle. mem_we=1, mem_a=ptr, mem_wd=assembled word. Then ptr+=4 and cnt-=1. If cnt reaches 0 -> RUN, else -> DATA.
- Latency: the write occurs the cycle after the 4th byte is accepted. The loader sees at most one stall cycle per word.
- RUN: mem_a=fetch_a (combinational passthrough), mem_we=0, cpu_hold=0, boot_done=1.
- ERR: cpu_hold=1, boot_err=1, in_ready=0, mem_we=0. It is sticky until reset or restart.
- Outside RUN, mem_a=ptr. Word 0 is never written by this block.
- restart (any state) -> HDR0 next cycle. All counters are cleared; cpu_hold=1, boot_done=0, boot_err=0. A byte offered in the same cycle as restart is not accepted.
- Async reset mid-load aborts immediately. Memory contents already written are left unchanged.
- in_valid low in DATA holds bidx; no timeout.
- ptr arithmetic is 32-bit. Wrap cannot occur because of the cnt bound.

Optional Feature:
- Macro: IMEM_BOOT_CKSUM_EN.
- When defined: after the last WRITE, the state goes to CKSUM (in_ready=1). One trailing byte is accepted and compared to the running XOR of all data bytes.
  - Equal -> RUN.
  - Mismatch -> ERR.
  - cnt==0 also passes through CKSUM, with expected value 8'h00.
- When undefined: no CKSUM state and no XOR register. The last WRITE goes directly to RUN.

Decomposition:
- Shared package imem_boot_pkg:
  - state enum boot_state_e {HDR0, HDR1, DATA, WRITE, CKSUM, RUN, ERR}
  - constant BOOT_HDR_BYTES=2
  - constant BYTES_PER_WORD=4
- Natural sub-module: imem_word_assembler (byte shift register plus 2-bit index, with optional XOR accumulator). The top level keeps the FSM and address mux.

Test Plan:
1. Bytes 00 02 | DE AD BE EF | 00 00 01 13 -> writes 0xDEADBEEF@0x4 and 0x00000113@0x8, mem_we one cycle each. Then boot_done=1 and cpu_hold=0; fetch_a=0x10 gives mem_a=0x10.
2. Header 00 00 -> RUN two cycles after the second byte; no mem_we pulses.
3. Header 04 00 (1024 > MEM_SIZE-1) -> boot_err=1 and in_ready=0. Then a restart pulse, followed by valid header 00 01 and one word, -> normal load.
4. in_valid toggled every other cycle during DATA -> identical writes; bidx holds; in_ready=0 only in WRITE cycles.
5. Async reset asserted after 2 of 4 bytes of word 3 -> all outputs return to reset values without waiting for a clock edge. A full reload succeeds afterwards.
6. (IMEM_BOOT_CKSUM_EN) 00 01 | 12 34 56 78 | checksum 0x08 -> RUN. Same stream with checksum 0x09 -> ERR, boot_err=1.
